// File: rtl/ha_token_fifo.sv
// Elastic token buffer between HA_INW and HA_TW: DEPTH slots, show-ahead head, occupancy and delivered-token counters.
// Latency: a push in cycle N is visible on DataOut_1 with Valid=1 in cycle N+1 (no empty bypass).
// Backpressure: DataIn_1_Ready depends only on registered Count (no ready pass-through); a pop at full frees a slot next cycle.
module ha_token_fifo #(
   parameter int DataIn_1_BW  = 32,
   parameter int DataOut_1_BW = 32,
   parameter int DEPTH        = 4,   // power of two, >= 2
   parameter int ADDR_W       = 2    // log2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DataIn_1_BW-1:0]  DataIn_1,
   input  logic                    DataIn_1_Valid,
   output logic                    DataIn_1_Ready,
   output logic [DataOut_1_BW-1:0] DataOut_1,
   output logic                    DataOut_1_Valid,
   input  logic                    DataOut_1_Ready,
   output logic [ADDR_W:0]         Count,
   output logic [31:0]             TokenCount
);

   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

   // Storage is DataOut_1_BW wide; width adaptation happens before the write.
   logic [DataOut_1_BW-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]       rd_ptr;
   logic [ADDR_W-1:0]       wr_ptr;
   logic [DataOut_1_BW-1:0] wr_data;
   logic                    push;
   logic                    pop;

   // Zero-extend narrow input, or keep the low bits of a wide input.
   generate
      if (DataOut_1_BW > DataIn_1_BW) begin : g_widen
         assign wr_data = {{(DataOut_1_BW-DataIn_1_BW){1'b0}}, DataIn_1};
      end else begin : g_narrow
         assign wr_data = DataIn_1[DataOut_1_BW-1:0];
      end
   endgenerate

   // Full/empty come from Count alone; pointer equality is ambiguous when full.
   assign DataIn_1_Ready  = (Count != CNT_FULL);
   assign DataOut_1_Valid = (Count != '0);
   assign push            = DataIn_1_Valid && DataIn_1_Ready;
   assign pop             = DataOut_1_Valid && DataOut_1_Ready;

   // Show-ahead head; forced to zero while empty so stale/unreset slots never leak out.
   assign DataOut_1 = DataOut_1_Valid ? mem[rd_ptr] : '0;

   // Token write into the slot at the write pointer; storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and delivered-token counter; reset drops any same-cycle handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         Count      <= '0;
         TokenCount <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            TokenCount <= TokenCount + 32'd1;
         end
         if (push && !pop) begin
            Count <= Count + CNT_ONE;
         end else if (pop && !push) begin
            Count <= Count - CNT_ONE;
         end
      end
   end

endmodule

// File: doc/ha_token_fifo.md
Name: ha_token_fifo

Overview:
- Elastic token buffer placed between an input wrapper (HA_INW) and a token stage (HA_TW) inside a generated DSE solution module.
- Decouples producer and consumer with a valid/ready handshake.
- Holds up to DEPTH data tokens and reports its occupancy and a delivered-token count for DSE profiling.
- Adapts the data width from DataIn_1_BW to DataOut_1_BW.

Parameters:
- DataIn_1_BW, 32, width of incoming token data.
- DataOut_1_BW, 32, width of outgoing token data.
- DEPTH, 4, number of token slots. Must be a power of two and at least 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- DataIn_1  input  DataIn_1_BW  token data from upstream.
- DataIn_1_Valid  input  1  upstream presents a token.
- DataIn_1_Ready  output  1  buffer can accept a token this cycle.
- DataOut_1  output  DataOut_1_BW  head token data to downstream.
- DataOut_1_Valid  output  1  head token is valid.
- DataOut_1_Ready  input  1  downstream accepts the head token.
- Count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- TokenCount  output  32  total tokens delivered since reset; wraps modulo 2^32.

Behaviour:
- Reset:
  - rst is sampled on the clk rising edge.
  - Clears the read pointer, write pointer, Count and TokenCount to 0.
  - Outputs after reset: DataOut_1_Valid=0, DataIn_1_Ready=1, DataOut_1=0.
  - Storage array contents are don't-care.
  - Reset asserted mid-transfer discards all held tokens; any handshake in that same cycle is ignored.
- Push: occurs when DataIn_1_Valid && DataIn_1_Ready. The token is written at the write pointer, which then increments modulo DEPTH.
- Pop: occurs when DataOut_1_Valid && DataOut_1_Ready. The read pointer increments modulo DEPTH and TokenCount increments by 1.
- Ready and valid:
  - DataIn_1_Ready = (Count != DEPTH). It is a combinational function of registered Count only, with no dependency on DataOut_1_Ready, so there is no pass-through ready path.
  - DataOut_1_Valid = (Count != 0).
  - DataOut_1 is driven from the storage slot at the read pointer. Show-ahead: the head token is visible without a pop.
- Latency: a token pushed in cycle N appears on DataOut_1 with Valid=1 in cycle N+1. There is no same-cycle bypass when empty.
- Occupancy update each cycle:
  - Push only: Count+1.
  - Pop only: Count-1.
  - Push and pop together: Count unchanged, both pointers advance.
- Full (Count=DEPTH): Ready=0, so no push. A pop this cycle makes Ready=1 in the next cycle.
- Empty (Count=0): Valid=0, so no pop. A push this cycle makes Valid=1 in the next cycle.
- Upstream protocol: DataIn_1_Valid may assert independently of Ready. Once asserted, upstream holds its data until accepted; the block does not check this.
- Width rule:
  - DataOut_1_BW > DataIn_1_BW: zero-extend at write.
  - DataOut_1_BW < DataIn_1_BW: keep the low DataOut_1_BW bits.
  - Storage width is DataOut_1_BW.
- Pointer wrap: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by Count, not by pointer equality.
- TokenCount wraps from 0xFFFFFFFF to 0 on the next pop.

Test Plan:
- Reset release, then push 0x11,0x22,0x33,0x44 with DataOut_1_Ready=0:
  - Count steps 1..4; DataIn_1_Ready=0 once Count=4.
  - DataOut_1=0x11, Valid=1 from the cycle after the first push.
- From full, hold DataOut_1_Ready=1 for 4 cycles:
  - Outputs 0x11,0x22,0x33,0x44 in order.
  - Ready returns to 1 the cycle after the first pop; TokenCount=4; Valid=0 after the last pop.
- Empty with continuous Valid/Ready=1 streaming 0x100..0x10F:
  - After the first-cycle latency, one token per cycle and Count stays 1.
  - Pointers wrap 4 times; data order is preserved and TokenCount=16.
- Full with DataIn_1_Valid=1 and DataIn_1_Ready=0 while a pop occurs:
  - The pending word 0x55 is not written in that cycle.
  - It is written in the next cycle; no loss and no duplicate.
- DataIn_1_BW=32, DataOut_1_BW=16, push 0xDEADBEEF -> DataOut_1=0xBEEF.
- DataIn_1_BW=8, DataOut_1_BW=16, push 0xA5 -> DataOut_1=0x00A5.
- Assert rst for 1 cycle with Count=3 -> next cycle Count=0, Valid=0, Ready=1, TokenCount=0.
